// File: rtl/mips_alu_pkg.sv
// Shared ALU control encodings and small helpers for the MIPS-style execute-stage ALU.
// Used by the ALU itself and by the ALU control decoder.
package mips_alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // True when alu_ctl names one of the implemented operations.
  function automatic logic is_legal_op(input logic [3:0] ctl);
    logic legal;
    case (ctl)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: legal = 1'b1;
      default:                                             legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage : mips_alu_pkg

// File: rtl/mips_alu_core.sv
// Combinational ALU datapath: selects one operation by alu_ctl and derives the zero flag.
// Unimplemented codes produce a defined zero result.
module mips_alu_core
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  logic [WIDTH-1:0] slt_one_s;
  logic             a_lt_b_s;

  assign slt_one_s = {{(WIDTH-1){1'b0}}, 1'b1};
  // Signed compare rather than the sign of a-b, which is wrong on overflow.
  assign a_lt_b_s  = ($signed(a) < $signed(b));

  // Operation select.
  always_comb begin
    result = {WIDTH{1'b0}};
    case (alu_ctl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: begin
        if (a_lt_b_s) begin
          result = slt_one_s;
        end else begin
          result = {WIDTH{1'b0}};
        end
      end
      ALU_NOR: result = ~(a | b);
      default: result = {WIDTH{1'b0}};
    endcase
  end

  assign zero = (result == {WIDTH{1'b0}});

endmodule : mips_alu_core

// File: rtl/mips_alu.sv
// Execute-stage ALU: registers the core result and zero flag, one clock of latency,
// with synchronous active-low reset.
module mips_alu
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero
);

  logic [WIDTH-1:0] result_s;
  logic             zero_s;

  mips_alu_core #(.WIDTH(WIDTH)) u_core (
    .a       (a),
    .b       (b),
    .alu_ctl (alu_ctl),
    .result  (result_s),
    .zero    (zero_s)
  );

  // Output register; reset drops any in-flight result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_out <= {WIDTH{1'b0}};
      zero    <= 1'b1;
    end else begin
      alu_out <= result_s;
      zero    <= zero_s;
    end
  end

endmodule : mips_alu

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed corner cases plus random operations
// compared against an integer-arithmetic reference model.
module tb_mips_alu;

  localparam int WIDTH = 8;
  localparam int MODV  = 1 << WIDTH;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] alu_out;
  logic             zero;

  int n_checks;
  int n_fail;

  mips_alu #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .alu_ctl (alu_ctl),
    .alu_out (alu_out),
    .zero    (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= MODV / 2) ? v - MODV : v;
  endfunction

  // Reference result from the opcode table using plain integer arithmetic.
  function automatic int ref_op(input int x, input int y, input int ctl);
    int r;
    case (ctl)
      0:  r = x & y;
      1:  r = x | y;
      2:  r = (x + y) % MODV;
      6:  r = (x - y + MODV) % MODV;
      7:  r = (to_signed(x) < to_signed(y)) ? 1 : 0;
      12: r = (MODV - 1) - (x | y);
      default: r = 0;
    endcase
    return r;
  endfunction

  task automatic apply(input string tag, input int x, input int y, input int ctl);
    int exp;
    a       = x[WIDTH-1:0];
    b       = y[WIDTH-1:0];
    alu_ctl = ctl[3:0];
    exp     = ref_op(x, y, ctl);
    @(posedge clk);
    #1;
    check({tag, "_out"}, int'(alu_out), exp);
    check({tag, "_zero"}, int'(zero), (exp == 0) ? 1 : 0);
  endtask

  initial begin
    int x, y, c;
    int ops[7];
    n_checks = 0;
    n_fail   = 0;
    ops = '{0, 1, 2, 6, 7, 12, 15};

    rst_n   = 1'b0;
    a       = 8'h00;
    b       = 8'h00;
    alu_ctl = 4'b0010;
    @(posedge clk);
    #1;
    check("reset_out", int'(alu_out), 0);
    check("reset_zero", int'(zero), 1);
    rst_n = 1'b1;

    apply("and",     8'h01, 8'h03, 4'b0000);
    apply("or",      8'h00, 8'h01, 4'b0001);
    apply("add",     8'h00, 8'h01, 4'b0010);
    apply("add_wrap",8'hFF, 8'h01, 4'b0010);
    apply("sub",     8'h00, 8'h01, 4'b0110);
    apply("sub_eq",  8'h5A, 8'h5A, 4'b0110);
    apply("slt_pos", 8'h00, 8'h01, 4'b0111);
    apply("slt_neg", 8'h80, 8'h01, 4'b0111);
    apply("slt_ovf", 8'h7F, 8'h80, 4'b0111);
    apply("nor",     8'h00, 8'h01, 4'b1100);
    apply("illegal", 8'h3C, 8'hA5, 4'b1111);
    apply("illegal3",8'h3C, 8'hA5, 4'b0011);

    // Reset mid-stream discards the pending result, then resumes.
    apply("pre_rst", 8'h12, 8'h34, 4'b0001);
    rst_n   = 1'b0;
    a       = 8'h10;
    b       = 8'h05;
    alu_ctl = 4'b0010;
    @(posedge clk);
    #1;
    check("rst_mid_out", int'(alu_out), 0);
    check("rst_mid_zero", int'(zero), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rel_out", int'(alu_out), 8'h15);
    check("rst_rel_zero", int'(zero), 0);

    for (int i = 0; i < 300; i++) begin
      x = int'($urandom_range(MODV - 1, 0));
      y = int'($urandom_range(MODV - 1, 0));
      if (i % 5 == 0) begin
        c = int'($urandom_range(15, 0));
      end else begin
        c = ops[$urandom_range(5, 0)];
      end
      if (i % 17 == 0) begin
        y = x;
      end
      apply("rand", x, y, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mips_alu
